uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART. It synchronizes the serial input and detects and validates start bits. It generates the mid-bit sample strobes that pace the RX datapath, checks the stop bit, and buffers completed bytes in a small FIFO with a ready/valid pop interface. It sits between the pad-level rxd line and the consuming logic (command parser / bus bridge), and owns all RX error reporting.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); must be >= 4.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
en  in  1  receiver enable; low forces IDLE
i_rxd  in  1  asynchronous serial input, idle high
bit_tick  out  1  one-cycle pulse at every sample point (start, data, parity, stop)
busy  out  1  high whenever the FSM is not in IDLE
rx_data  out  8  FIFO head byte (first-word-fall-through)
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pop; a pop occurs when rx_valid && rx_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
frame_err  out  1  sticky: stop bit sampled 0
overrun_err  out  1  sticky: byte dropped because FIFO was full
parity_err  out  1  sticky: parity mismatch (tied 0 without the macro)
clr_err  in  1  one-cycle pulse clears all sticky errors

Behaviour:
- Reset: all state is cleared synchronously when reset==0 at a clk edge.
  - FSM goes to IDLE; sync regs go to 1; counters go to 0; FIFO is emptied.
  - All outputs go to 0: bit_tick=0, busy=0, rx_data=0x00, rx_valid=0, fifo_count=0, all errors 0.
  - Reset mid-frame discards the partial byte.
- Input sync: 2-FF synchronizer on i_rxd; all logic uses the second stage (rxd_s). This adds 2 cycles of latency.
- Bit counter: cnt runs 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: if en && rxd_s==0, go to START with cnt=0.
  - START: at cnt==HALF-1, pulse bit_tick and check rxd_s.
    - rxd_s==0: go to DATA with cnt=0, bit_idx=0.
    - rxd_s==1: glitch; return to IDLE with no error.
  - DATA: at cnt==CLKS_PER_BIT-1, pulse bit_tick and shift rxd_s into the shift register LSB-first (shift right, sample enters bit 7).
    - bit_idx increments on each sample.
    - After the 8th sample (bit_idx==7), go to PARITY if the macro is defined, else STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, pulse bit_tick and check rxd_s.
    - rxd_s==1: push the byte.
    - rxd_s==0: set frame_err and drop the byte.
    - Either way, return to IDLE in the same cycle. A 0 still on the line re-arms START on the next cycle.
- en deasserted: the FSM returns to IDLE on the next edge and any in-flight byte is discarded. FIFO contents and error flags are retained.
- FIFO:
  - Circular buffer; pointer width $clog2(FIFO_DEPTH), wraps naturally.
  - A pushed byte is visible on rx_data with rx_valid=1 on the cycle after the push edge.
  - Full and no pop: the push is dropped and overrun_err is set; existing entries are unchanged.
  - Full with a simultaneous pop: the push is accepted and fifo_count is unchanged.
  - Empty: a pop request is ignored. rx_data holds the last value when empty.
  - Simultaneous push and pop on a non-empty FIFO: count is unchanged.
- Errors:
  - Flags are sticky until clr_err.
  - If clr_err coincides with a new error event, the set wins.
- busy = (state != IDLE), registered.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state follows DATA. At cnt==CLKS_PER_BIT-1, pulse bit_tick and sample the parity bit.
  - Check: XOR(data, parity_bit) must equal PARITY_ODD.
  - Mismatch: set parity_err; the byte is dropped at STOP, even if the stop bit is good.
  - Frame length: 11 bits.
- Undefined: no PARITY state; parity_err is tied to 0; frame is 10 bits (8N1).

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5, rx_ready=0.
  - rx_valid rises 2+8+9*16+1=155 cycles after the i_rxd falling edge; rx_data=0xA5; fifo_count=1; no errors.
  - bit_tick pulses exactly 10 times.
- 0.25-bit low glitch (4 cycles) on an idle line → FSM returns to IDLE after the START check; no push, no error, busy low afterwards.
- Send 0x3C with the stop bit forced 0 → frame_err=1, fifo_count=0. Then pulse clr_err → frame_err=0.
- FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05.
  - fifo_count=4, overrun_err=1.
  - Popping returns 0x01,0x02,0x03,0x04, then rx_valid=0.
- FIFO full with rx_ready=1 held as the 5th byte's stop bit is sampled → push accepted, fifo_count stays 4, overrun_err=0.
- Reset low during bit 4 of 0xFF → all outputs 0 next edge. A following 0x81 is received correctly.
- With UART_RX_PARITY_EN, PARITY_ODD=0:
  - 0x07 with parity bit 1 is accepted.
  - 0x07 with parity bit 0 sets parity_err and the byte is not pushed.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: rxd sync, start/stop validation, mid-bit strobes, FWFT byte FIFO. Parity via UART_RX_PARITY_EN.
// Latency: 2 sync cycles plus the frame; a byte appears on rx_data/rx_valid the cycle after its stop-bit sample.
// Backpressure: rx_valid/rx_ready pop; a byte arriving at a full FIFO with no same-cycle pop is dropped (overrun_err).
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          i_rxd,
    output logic                          bit_tick,
    output logic                          busy,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err,
    input  logic                          clr_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic          rxd_m, rxd_s;
    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick_nx, shift_en, push_req, ferr_set, perr_set;
    logic          par_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
    logic          do_pop, do_push, full, ovr_set;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        tick_nx  = 1'b0;
        shift_en = 1'b0;
        push_req = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (!rxd_s) state_nx = S_START;
            end
            S_START: if (cnt == HALF_M1) begin
                tick_nx  = 1'b1;
                cnt_nx   = '0;
                state_nx = rxd_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt == FULL_M1) begin
                tick_nx  = 1'b1;
                cnt_nx   = '0;
                shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx == 3'd7) state_nx = S_PARITY;
`else
                if (bit_idx == 3'd7) state_nx = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (cnt == FULL_M1) begin
                tick_nx  = 1'b1;
                cnt_nx   = '0;
                perr_set = ((^shreg) ^ rxd_s) != PARITY_ODD;
                state_nx = S_STOP;
            end
`endif
            S_STOP: if (cnt == FULL_M1) begin
                tick_nx  = 1'b1;
                cnt_nx   = '0;
                state_nx = S_IDLE;
                push_req = rxd_s & ~par_bad;
                ferr_set = ~rxd_s;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
        // Disabling kills the frame in flight, including any event due this cycle.
        if (!en) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            tick_nx  = 1'b0;
            shift_en = 1'b0;
            push_req = 1'b0;
            ferr_set = 1'b0;
            perr_set = 1'b0;
        end
    end

    assign rx_valid   = (fifo_count != '0);
    assign full       = (fifo_count == DEPTH_C);
    assign do_pop     = rx_valid & rx_ready;
    assign do_push    = push_req & (~full | do_pop);
    assign ovr_set    = push_req & full & ~do_pop;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rxd_m       <= 1'b1;
            rxd_s       <= 1'b1;
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            bit_tick    <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rx_data     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            rxd_m    <= i_rxd;
            rxd_s    <= rxd_m;
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_tick <= tick_nx;
            busy     <= (state_nx != S_IDLE);
            if (shift_en)             bit_idx <= bit_idx + 1'b1;
            else if (state != S_DATA) bit_idx <= '0;
            if (shift_en) shreg <= {rxd_s, shreg[7:1]};

            frame_err   <= ferr_set | (frame_err & ~clr_err);
            overrun_err <= ovr_set | (overrun_err & ~clr_err);

            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr_inc;
            if (do_push && !do_pop)      fifo_count <= fifo_count + 1'b1;
            else if (do_pop && !do_push) fifo_count <= fifo_count - 1'b1;
            // rx_data is a registered copy of the head so it holds its last value once empty.
            if (do_push && (fifo_count == '0 || (do_pop && fifo_count == 1)))
                rx_data <= shreg;
            else if (do_pop && fifo_count > 1)
                rx_data <= mem[rd_ptr_inc];
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == S_START) par_bad <= 1'b0;
            else if (perr_set)    par_bad <= 1'b1;
            parity_err <= perr_set | (parity_err & ~clr_err);
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = PARITY_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level reference model (byte queue + sticky flags) against directed and random frames.
module tb_uart_rx_ctrl;
    localparam int CPB     = 16;
    localparam int DEPTH   = 4;
    localparam int HALF    = CPB / 2;
    localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edge (counted from the start-bit drive) at which a frame's byte lands:
    // 2 sync edges, half a bit to the start check, one bit per remaining frame bit, then the push edge.
    localparam int PUSH_K = 2 + HALF + (NB - 1) * CPB + 1;

    logic       clk = 1'b0;
    logic       reset, en, i_rxd, rx_ready, clr_err;
    logic       bit_tick, busy, rx_valid, frame_err, overrun_err, parity_err;
    logic [7:0] rx_data;
    logic [2:0] fifo_count;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PAR_ODD)) dut (
        .clk(clk), .reset(reset), .en(en), .i_rxd(i_rxd),
        .bit_tick(bit_tick), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_count(fifo_count), .frame_err(frame_err),
        .overrun_err(overrun_err), .parity_err(parity_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    bit         m_ferr, m_oerr, m_perr;
    int         k, ticks, lat, push_k;
    logic [7:0] push_b;
    bit         push_ok;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, model pops before pushes on the same edge, sample at next negedge.
    task automatic cyc(input logic v, input bit rdy);
        i_rxd    = v;
        rx_ready = rdy;
        if (rdy && q.size() > 0) chk("pop_data", rx_data, q[0]);
        @(posedge clk);
        k++;
        if (rdy && q.size() > 0) q.delete(0);
        if (k == push_k && push_ok) begin
            if (q.size() < DEPTH) q.push_back(push_b);
            else m_oerr = 1'b1;
        end
        @(negedge clk);
        if (bit_tick) ticks++;
        if (rx_valid && lat == 0) lat = k;
        chk("count", fifo_count, q.size());
        chk("valid", rx_valid, q.size() != 0);
    endtask

    task automatic chk_err();
        chk("frame_err", frame_err, m_ferr);
        chk("overrun_err", overrun_err, m_oerr);
        chk("parity_err", parity_err, m_perr);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stopb, input bit flip, input int pop_k);
        logic v [NB];
        bit   pbad, was_empty;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[i+1] = b[i];
`ifdef UART_RX_PARITY_EN
        v[9] = (^b) ^ PAR_ODD ^ flip;
        pbad = flip;
`else
        pbad = 1'b0;
        if (flip) pbad = 1'b0;
`endif
        v[NB-1]   = stopb;
        push_b    = b;
        push_ok   = stopb && !pbad;
        push_k    = PUSH_K;
        was_empty = (q.size() == 0);
        k = 0; ticks = 0; lat = 0;
        for (int i = 0; i < NB; i++)
            repeat (CPB) cyc(v[i], (k + 1 == pop_k));
        repeat (20) cyc(1'b1, 1'b0);
        push_k = -1;
        if (!stopb) m_ferr = 1'b1;
        if (pbad)   m_perr = 1'b1;
        // A bad stop bit leaves the line low long enough to re-arm a start that then fails its check.
        chk("ticks", ticks, stopb ? NB : NB + 1);
        if (was_empty && push_ok && pop_k < 0) chk("latency", lat, PUSH_K);
        if (q.size() > 0) chk("head", rx_data, q[0]);
        chk("busy_after", busy, 1'b0);
        chk_err();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        cyc(1'b1, 1'b0);
        clr_err = 1'b0;
        m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
        chk_err();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 4 && q.size() > 0; i++) cyc(1'b1, 1'b1);
        chk("drained", rx_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; i_rxd = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
        m_ferr = 0; m_oerr = 0; m_perr = 0; push_k = -1; push_ok = 0; push_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tick", bit_tick, 1'b0);
        chk_err();
        reset = 1'b1;
        repeat (4) cyc(1'b1, 1'b0);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        chk("a5_data", rx_data, 8'hA5);
        drain();

        // Quarter-bit glitch on an idle line.
        k = 0; ticks = 0; push_k = -1;
        repeat (4) cyc(1'b0, 1'b0);
        repeat (20) cyc(1'b1, 1'b0);
        chk("glitch_ticks", ticks, 1);
        chk("glitch_busy", busy, 1'b0);
        chk_err();

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        chk("ferr_set", frame_err, 1'b1);
        clear_errs();

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
        chk("ovr_count", fifo_count, 4);
        chk("ovr_flag", overrun_err, 1'b1);
        drain();
        clear_errs();

        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, -1);
        send_frame(8'h14, 1'b1, 1'b0, PUSH_K);
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_ovr", overrun_err, 1'b0);
        drain();

        // Enable dropped mid-frame: partial byte discarded, nothing else disturbed.
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        k = 0; push_k = -1;
        repeat (16) cyc(1'b0, 1'b0);
        repeat (40) cyc(1'b1, 1'b0);
        en = 1'b0;
        cyc(1'b1, 1'b0);
        chk("en_busy", busy, 1'b0);
        en = 1'b1;
        repeat (140) cyc(1'b1, 1'b0);
        chk_err();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, -1);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        chk("par_flag", parity_err, 1'b1);
        drain();
        clear_errs();
`endif

        for (int n = 0; n < 16; n++) begin
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, -1);
            idle($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) clear_errs();
        end
        drain();

        // Reset during data bit 4 of 0xFF, with a byte and a sticky error pending.
        send_frame(8'h66, 1'b1, 1'b0, -1);
        send_frame(8'h99, 1'b0, 1'b0, -1);
        k = 0; push_k = -1;
        repeat (16) cyc(1'b0, 1'b0);
        repeat (CPB * 3 + HALF) cyc(1'b1, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        q.delete();
        m_ferr = 0; m_oerr = 0; m_perr = 0;
        @(negedge clk);
        chk("mid_rst_valid", rx_valid, 1'b0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_data", rx_data, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_tick", bit_tick, 1'b0);
        chk_err();
        reset = 1'b1;
        repeat (CPB * 6) cyc(1'b1, 1'b0);
        chk("post_rst_count", fifo_count, 0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        chk("post_rst_data", rx_data, 8'h81);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
